// File: rtl/spi_master_arbiter.sv
// ============================================================================
// spi_master_arbiter
// ----------------------------------------------------------------------------
// Shares a single spi_master (cs_addr / packet_size / recv / send val-rdy
// interfaces) among NREQ requesters. A round-robin arbiter grants one complete
// SPI transaction at a time:
//   IDLE -> CFG (cs_addr + packet_size) -> XFER (data to master)
//        -> WAIT (response from master) -> RESP (route back) -> IDLE
//
// Handshake semantics (every val/rdy pair in this block):
//   A transfer happens on a rising clk edge where val and rdy are both 1.
//   A producer holds val and msg stable until that transfer; val never
//   depends combinationally on the matching rdy. The only combinational
//   rdy in this block is req_rdy_o, which depends on req_val_i while IDLE.
//
// Optional feature:
//   SPI_ARB_TIMEOUT_EN  when defined, WAIT aborts after TIMEOUT cycles with no
//                       master response: timeout_o pulses for one cycle and
//                       the requester receives all-ones. When undefined, WAIT
//                       lasts until the master answers and timeout_o is 0.
//
// Ports:
//   clk_i, reset_ni              clock, asynchronous active-low reset
//   req_val_i/req_rdy_o          per-requester request handshake
//   req_msg_i/req_cs_i/req_size_i  per-requester data, chip select, size;
//                                requester i at [i*W +: W]
//   resp_val_o/resp_rdy_i        per-requester response handshake
//   resp_msg_o                   shared response data, qualified by resp_val_o
//   m_cs_addr_*                  cs address interface to the master
//   m_pkt_size_*                 packet size interface to the master
//   m_recv_*                     data word to the master
//   m_send_*                     response word from the master
//   grant_id_o                   index of current/last grant
//   busy_o                       high in any state other than IDLE
//   timeout_o                    one-cycle pulse on WAIT abort
//   state_o                      current FSM state (debug)
// ============================================================================
module spi_master_arbiter #(
    parameter  int NREQ    = 4,
    parameter  int NBITS   = 32,
    parameter  int CS_W    = 3,
    parameter  int SIZE_W  = 6,
    parameter  int TIMEOUT = 1024,
    localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,

    input  logic [NREQ-1:0]          req_val_i,
    output logic [NREQ-1:0]          req_rdy_o,
    input  logic [NREQ*NBITS-1:0]    req_msg_i,
    input  logic [NREQ*CS_W-1:0]     req_cs_i,
    input  logic [NREQ*SIZE_W-1:0]   req_size_i,

    output logic [NREQ-1:0]          resp_val_o,
    input  logic [NREQ-1:0]          resp_rdy_i,
    output logic [NBITS-1:0]         resp_msg_o,

    output logic                     m_cs_addr_val_o,
    input  logic                     m_cs_addr_rdy_i,
    output logic [CS_W-1:0]          m_cs_addr_msg_o,

    output logic                     m_pkt_size_val_o,
    input  logic                     m_pkt_size_rdy_i,
    output logic [SIZE_W-1:0]        m_pkt_size_msg_o,

    output logic                     m_recv_val_o,
    input  logic                     m_recv_rdy_i,
    output logic [NBITS-1:0]         m_recv_msg_o,

    input  logic                     m_send_val_i,
    output logic                     m_send_rdy_o,
    input  logic [NBITS-1:0]         m_send_msg_i,

    output logic [GW-1:0]            grant_id_o,
    output logic                     busy_o,
    output logic                     timeout_o,
    output logic [2:0]               state_o
);

    // Elaboration-time sanity check on the configuration.
    if (NREQ < 2 || TIMEOUT < 1) begin : g_bad_params
        $error("spi_master_arbiter: NREQ must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CFG  = 3'd1,
        S_XFER = 3'd2,
        S_WAIT = 3'd3,
        S_RESP = 3'd4
    } state_e;

    state_e             state_q, state_d;

    logic [GW-1:0]      rr_ptr_q;
    logic [GW-1:0]      grant_id_q;
    logic [NBITS-1:0]   data_q;
    logic [CS_W-1:0]    cs_q;
    logic [SIZE_W-1:0]  size_q;
    logic [NBITS-1:0]   resp_q;
    logic               cs_done_q;
    logic               sz_done_q;

    // ------------------------------------------------------------------
    // Round-robin pick: first requester at or above rr_ptr_q, wrapping.
    // ------------------------------------------------------------------
    logic               pick_found;
    logic [GW-1:0]      pick_idx;
    logic [GW:0]        scan_sum;
    logic [GW-1:0]      scan_idx;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (GW+1)'(k);
            if (scan_sum >= (GW+1)'(NREQ)) begin
                scan_sum = scan_sum - (GW+1)'(NREQ);
            end
            scan_idx = scan_sum[GW-1:0];
            if (!pick_found && req_val_i[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    // Winner drops to lowest priority for the next round.
    logic [GW-1:0] rr_next;
    assign rr_next = (pick_idx == GW'(NREQ-1)) ? '0 : pick_idx + GW'(1);

    // ------------------------------------------------------------------
    // Handshake fire conditions
    // ------------------------------------------------------------------
    logic grant;
    logic cs_fire;
    logic sz_fire;
    logic cfg_complete;
    logic recv_fire;
    logic send_fire;
    logic resp_fire;
    logic abort;

    assign grant        = (state_q == S_IDLE) && pick_found;
    assign cs_fire      = (state_q == S_CFG) && !cs_done_q && m_cs_addr_rdy_i;
    assign sz_fire      = (state_q == S_CFG) && !sz_done_q && m_pkt_size_rdy_i;
    // Both config words may fire in the same cycle or in any order.
    assign cfg_complete = (cs_done_q || cs_fire) && (sz_done_q || sz_fire);
    assign recv_fire    = (state_q == S_XFER) && m_recv_rdy_i;
    assign send_fire    = (state_q == S_WAIT) && m_send_val_i;
    assign resp_fire    = (state_q == S_RESP) && resp_rdy_i[grant_id_q];

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt_q;

    // The counter holds the number of WAIT cycles already elapsed, so the
    // TIMEOUT-th WAIT cycle sees TIMEOUT-1. A master response on that same
    // cycle still wins because abort requires !m_send_val_i.
    assign abort = (state_q == S_WAIT) && !m_send_val_i &&
                   (wait_cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wait_cnt_q <= '0;
        end else if (state_q != S_WAIT) begin
            wait_cnt_q <= '0;
        end else if (wait_cnt_q != CW'(TIMEOUT - 1)) begin
            wait_cnt_q <= wait_cnt_q + CW'(1);
        end
    end
`else
    assign abort = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (grant)               state_d = S_CFG;
            S_CFG:  if (cfg_complete)        state_d = S_XFER;
            S_XFER: if (recv_fire)           state_d = S_WAIT;
            S_WAIT: if (send_fire || abort)  state_d = S_RESP;
            S_RESP: if (resp_fire)           state_d = S_IDLE;
            default:                         state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
            data_q     <= '0;
            cs_q       <= '0;
            size_q     <= '0;
            resp_q     <= '0;
            cs_done_q  <= 1'b0;
            sz_done_q  <= 1'b0;
        end else begin
            if (grant) begin
                // Request contents are captured here, so a later drop of
                // req_val or change of req_msg does not affect this grant.
                data_q     <= req_msg_i[pick_idx*NBITS +: NBITS];
                cs_q       <= req_cs_i[pick_idx*CS_W +: CS_W];
                size_q     <= req_size_i[pick_idx*SIZE_W +: SIZE_W];
                grant_id_q <= pick_idx;
                rr_ptr_q   <= rr_next;
                cs_done_q  <= 1'b0;
                sz_done_q  <= 1'b0;
            end
            if (cs_fire) begin
                cs_done_q <= 1'b1;
            end
            if (sz_fire) begin
                sz_done_q <= 1'b1;
            end
            if (send_fire) begin
                resp_q <= m_send_msg_i;
            end else if (abort) begin
                resp_q <= '1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: output logic
    // ------------------------------------------------------------------
    always_comb begin
        req_rdy_o        = '0;
        resp_val_o       = '0;
        m_cs_addr_val_o  = 1'b0;
        m_pkt_size_val_o = 1'b0;
        m_recv_val_o     = 1'b0;
        m_send_rdy_o     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    req_rdy_o = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
                end
            end
            S_CFG: begin
                m_cs_addr_val_o  = !cs_done_q;
                m_pkt_size_val_o = !sz_done_q;
            end
            S_XFER: m_recv_val_o = 1'b1;
            S_WAIT: m_send_rdy_o = 1'b1;
            S_RESP: resp_val_o   = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_q;
            default: ;
        endcase
    end

    assign m_cs_addr_msg_o  = cs_q;
    assign m_pkt_size_msg_o = size_q;
    assign m_recv_msg_o     = data_q;
    assign resp_msg_o       = resp_q;
    assign grant_id_o       = grant_id_q;
    assign busy_o           = (state_q != S_IDLE);
    assign timeout_o        = abort;
    assign state_o          = state_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed testbench for spi_master_arbiter. The bench plays the role of the
// requesters and of the spi_master. Inputs change just after the falling
// edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_spi_master_arbiter;
  localparam int NREQ    = 4;
  localparam int NBITS   = 32;
  localparam int CS_W    = 3;
  localparam int SIZE_W  = 6;
  localparam int TIMEOUT = 8;
  localparam int GW      = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_ni = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]        req_val_i = '0;
  logic [NREQ-1:0]        req_rdy_o;
  logic [NREQ*NBITS-1:0]  req_msg_i = '0;
  logic [NREQ*CS_W-1:0]   req_cs_i = '0;
  logic [NREQ*SIZE_W-1:0] req_size_i = '0;
  logic [NREQ-1:0]        resp_val_o;
  logic [NREQ-1:0]        resp_rdy_i = '0;
  logic [NBITS-1:0]       resp_msg_o;
  logic                   m_cs_addr_val_o;
  logic                   m_cs_addr_rdy_i = 1'b0;
  logic [CS_W-1:0]        m_cs_addr_msg_o;
  logic                   m_pkt_size_val_o;
  logic                   m_pkt_size_rdy_i = 1'b0;
  logic [SIZE_W-1:0]      m_pkt_size_msg_o;
  logic                   m_recv_val_o;
  logic                   m_recv_rdy_i = 1'b0;
  logic [NBITS-1:0]       m_recv_msg_o;
  logic                   m_send_val_i = 1'b0;
  logic                   m_send_rdy_o;
  logic [NBITS-1:0]       m_send_msg_i = '0;
  logic [GW-1:0]          grant_id_o;
  logic                   busy_o;
  logic                   timeout_o;
  logic [2:0]             state_o;

  int checks = 0;
  int failures = 0;
  logic [NBITS-1:0] exp_q[$];

  spi_master_arbiter #(
    .NREQ(NREQ), .NBITS(NBITS), .CS_W(CS_W), .SIZE_W(SIZE_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .req_val_i(req_val_i), .req_rdy_o(req_rdy_o), .req_msg_i(req_msg_i),
    .req_cs_i(req_cs_i), .req_size_i(req_size_i),
    .resp_val_o(resp_val_o), .resp_rdy_i(resp_rdy_i), .resp_msg_o(resp_msg_o),
    .m_cs_addr_val_o(m_cs_addr_val_o), .m_cs_addr_rdy_i(m_cs_addr_rdy_i),
    .m_cs_addr_msg_o(m_cs_addr_msg_o),
    .m_pkt_size_val_o(m_pkt_size_val_o), .m_pkt_size_rdy_i(m_pkt_size_rdy_i),
    .m_pkt_size_msg_o(m_pkt_size_msg_o),
    .m_recv_val_o(m_recv_val_o), .m_recv_rdy_i(m_recv_rdy_i), .m_recv_msg_o(m_recv_msg_o),
    .m_send_val_i(m_send_val_i), .m_send_rdy_o(m_send_rdy_o), .m_send_msg_i(m_send_msg_i),
    .grant_id_o(grant_id_o), .busy_o(busy_o), .timeout_o(timeout_o), .state_o(state_o)
  );

  // ---------------- driver tasks ----------------
  task automatic clear_master();
    m_cs_addr_rdy_i = 1'b0;
    m_pkt_size_rdy_i = 1'b0;
    m_recv_rdy_i = 1'b0;
    m_send_val_i = 1'b0;
    m_send_msg_i = '0;
    resp_rdy_i = '0;
  endtask

  // Called just after a negedge while a grant is in progress. Acts as an
  // always-ready master and an always-ready requester until the response
  // has been accepted; returns at a negedge with the DUT back in IDLE.
  task automatic finish_txn(input logic [NBITS-1:0] send_data,
                            output logic [NBITS-1:0] recv_seen,
                            output logic [NREQ-1:0] rv_seen,
                            output logic [NBITS-1:0] rm_seen,
                            output bit ok);
    ok = 1'b0;
    recv_seen = '0;
    rv_seen = '0;
    rm_seen = '0;
    m_cs_addr_rdy_i = 1'b1;
    m_pkt_size_rdy_i = 1'b1;
    m_recv_rdy_i = 1'b1;
    m_send_val_i = 1'b1;
    m_send_msg_i = send_data;
    for (int n = 0; n < 100; n++) begin
      #1;
      if (m_recv_val_o) recv_seen = m_recv_msg_o;
      if (resp_val_o != '0) begin
        rv_seen = resp_val_o;
        rm_seen = resp_msg_o;
        resp_rdy_i = resp_val_o;
      end
      @(negedge clk);
      resp_rdy_i = '0;
      if (rv_seen != '0) begin
        ok = 1'b1;
        break;
      end
    end
    clear_master();
  endtask

  // Called just after a negedge with req_val_i already set. Waits for a
  // grant, then completes the transaction.
  task automatic do_txn(input logic [NBITS-1:0] send_data,
                        output logic [NREQ-1:0] rdy_seen,
                        output logic [NBITS-1:0] recv_seen,
                        output logic [NREQ-1:0] rv_seen,
                        output logic [NBITS-1:0] rm_seen,
                        output bit ok);
    rdy_seen = '0;
    recv_seen = '0;
    rv_seen = '0;
    rm_seen = '0;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (req_rdy_o != '0) break;
      @(negedge clk);
    end
    if (req_rdy_o == '0) return;
    rdy_seen = req_rdy_o;
    @(negedge clk);
    finish_txn(send_data, recv_seen, rv_seen, rm_seen, ok);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_ni = 1'b0;
    req_val_i = '0;
    clear_master();
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    reset_ni = 1'b0;
    #1;
    checks++;
    if ({busy_o, req_rdy_o, resp_val_o, m_cs_addr_val_o, m_pkt_size_val_o, m_recv_val_o, m_send_rdy_o} !== '0) begin
      failures++;
      $display("FAIL reset_outs busy=%b req_rdy=%b resp_val=%b cs=%b sz=%b recv=%b send_rdy=%b exp all 0",
               busy_o, req_rdy_o, resp_val_o, m_cs_addr_val_o, m_pkt_size_val_o, m_recv_val_o, m_send_rdy_o);
    end
    checks++;
    if ({grant_id_o, resp_msg_o, m_recv_msg_o, m_cs_addr_msg_o, m_pkt_size_msg_o, timeout_o} !== '0) begin
      failures++;
      $display("FAIL reset_regs grant=%0d resp_msg=%h recv_msg=%h cs=%0d sz=%0d to=%b exp 0",
               grant_id_o, resp_msg_o, m_recv_msg_o, m_cs_addr_msg_o, m_pkt_size_msg_o, timeout_o);
    end
    @(negedge clk);
    reset_ni = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    req_val_i = 4'b0100;
    req_msg_i[2*NBITS +: NBITS] = 32'hA5A5_0001;
    req_cs_i[2*CS_W +: CS_W] = 3'd3;
    req_size_i[2*SIZE_W +: SIZE_W] = 6'd16;
    #1;
    checks++;
    if (req_rdy_o !== 4'b0100) begin failures++; $display("FAIL basic_req_rdy got=%b exp=0100", req_rdy_o); end
    @(negedge clk);
    req_val_i = '0;
    #1;
    checks++;
    if ({m_cs_addr_val_o, m_pkt_size_val_o, m_recv_val_o, busy_o, req_rdy_o} !== 8'b1101_0000) begin
      failures++;
      $display("FAIL basic_cfg_vals got cs=%b sz=%b recv=%b busy=%b req_rdy=%b exp 1 1 0 1 0000",
               m_cs_addr_val_o, m_pkt_size_val_o, m_recv_val_o, busy_o, req_rdy_o);
    end
    checks++;
    if (m_cs_addr_msg_o !== 3'd3 || m_pkt_size_msg_o !== 6'd16 || grant_id_o !== 2'd2) begin
      failures++;
      $display("FAIL basic_cfg_msgs cs=%0d sz=%0d grant=%0d exp 3 16 2", m_cs_addr_msg_o, m_pkt_size_msg_o, grant_id_o);
    end
    m_cs_addr_rdy_i = 1'b1;
    m_pkt_size_rdy_i = 1'b1;
    @(negedge clk);
    m_cs_addr_rdy_i = 1'b0;
    m_pkt_size_rdy_i = 1'b0;
    #1;
    checks++;
    if ({m_cs_addr_val_o, m_pkt_size_val_o, m_recv_val_o} !== 3'b001 || m_recv_msg_o !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL basic_xfer cs=%b sz=%b recv=%b msg=%h exp 0 0 1 a5a50001",
               m_cs_addr_val_o, m_pkt_size_val_o, m_recv_val_o, m_recv_msg_o);
    end
    m_recv_rdy_i = 1'b1;
    @(negedge clk);
    m_recv_rdy_i = 1'b0;
    #1;
    checks++;
    if ({m_recv_val_o, m_send_rdy_o, timeout_o} !== 3'b010) begin
      failures++;
      $display("FAIL basic_wait recv=%b send_rdy=%b to=%b exp 0 1 0", m_recv_val_o, m_send_rdy_o, timeout_o);
    end
    m_send_val_i = 1'b1;
    m_send_msg_i = 32'h0000_BEEF;
    @(negedge clk);
    m_send_val_i = 1'b0;
    m_send_msg_i = '0;
    #1;
    checks++;
    if (resp_val_o !== 4'b0100 || resp_msg_o !== 32'h0000_BEEF || m_send_rdy_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_resp val=%b msg=%h send_rdy=%b exp 0100 0000beef 0", resp_val_o, resp_msg_o, m_send_rdy_o);
    end
    resp_rdy_i = 4'b0100;
    @(negedge clk);
    resp_rdy_i = '0;
    #1;
    checks++;
    if (resp_val_o !== 4'b0000 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL basic_done val=%b busy=%b exp 0000 0", resp_val_o, busy_o);
    end
  endtask

  task automatic test_reset_mid_xfer();
    logic [NREQ-1:0] rdy_s, rv_s;
    logic [NBITS-1:0] recv_s, rm_s;
    bit ok;
    @(negedge clk);
    req_val_i = 4'b0010;
    req_msg_i[1*NBITS +: NBITS] = 32'h1111_2222;
    @(negedge clk);
    req_val_i = '0;
    m_cs_addr_rdy_i = 1'b1;
    m_pkt_size_rdy_i = 1'b1;
    @(negedge clk);
    clear_master();
    #1;
    checks++;
    if (m_recv_val_o !== 1'b1 || grant_id_o !== 2'd1) begin
      failures++;
      $display("FAIL rst_pre_xfer recv=%b grant=%0d exp 1 1", m_recv_val_o, grant_id_o);
    end
    reset_ni = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if ({m_recv_val_o, m_cs_addr_val_o, m_pkt_size_val_o, m_send_rdy_o, resp_val_o, busy_o, grant_id_o} !== '0) begin
      failures++;
      $display("FAIL rst_mid_xfer recv=%b cs=%b sz=%b send_rdy=%b resp=%b busy=%b grant=%0d exp all 0",
               m_recv_val_o, m_cs_addr_val_o, m_pkt_size_val_o, m_send_rdy_o, resp_val_o, busy_o, grant_id_o);
    end
    reset_ni = 1'b1;
    @(negedge clk);
    // rr pointer is back at 0, so requester 1 beats requester 3.
    req_val_i = 4'b1010;
    req_msg_i[3*NBITS +: NBITS] = 32'h3333_4444;
    do_txn(32'hCAFE_0001, rdy_s, recv_s, rv_s, rm_s, ok);
    req_val_i = '0;
    checks++;
    if (ok !== 1'b1 || rdy_s !== 4'b0010 || recv_s !== 32'h1111_2222 || rv_s !== 4'b0010 || rm_s !== 32'hCAFE_0001) begin
      failures++;
      $display("FAIL rst_after_serve ok=%b rdy=%b recv=%h rv=%b rm=%h exp 1 0010 11112222 0010 cafe0001",
               ok, rdy_s, recv_s, rv_s, rm_s);
    end
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] rdy_s, rv_s;
    logic [NBITS-1:0] recv_s, rm_s, e;
    bit ok;
    apply_reset();
    @(negedge clk);
    for (int i = 0; i < NREQ; i++) begin
      req_msg_i[i*NBITS +: NBITS] = 32'h1000_0000 + 32'(i);
      req_cs_i[i*CS_W +: CS_W] = CS_W'(i + 1);
      req_size_i[i*SIZE_W +: SIZE_W] = SIZE_W'(8 + i);
    end
    exp_q = {32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    req_val_i = 4'b1111;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      do_txn(32'h5000_0000 + e, rdy_s, recv_s, rv_s, rm_s, ok);
      checks++;
      if (ok !== 1'b1 || rdy_s !== (4'b0001 << e[1:0]) || recv_s !== 32'h1000_0000 + e ||
          rv_s !== (4'b0001 << e[1:0]) || rm_s !== 32'h5000_0000 + e) begin
        failures++;
        $display("FAIL rr_grant_%0d ok=%b rdy=%b recv=%h rv=%b rm=%h exp rdy/rv one-hot of %0d",
                 e, ok, rdy_s, recv_s, rv_s, rm_s, e);
      end
    end
    req_val_i = '0;
  endtask

  task automatic test_cfg_split();
    logic [NREQ-1:0] rv_s;
    logic [NBITS-1:0] recv_s, rm_s;
    bit ok;
    @(negedge clk);
    req_val_i = 4'b0001;
    #1;
    checks++;
    if (req_rdy_o !== 4'b0001) begin failures++; $display("FAIL split_req_rdy got=%b exp=0001", req_rdy_o); end
    @(negedge clk);  // CFG cycle 1
    req_val_i = '0;
    m_cs_addr_rdy_i = 1'b1;
    #1;
    checks++;
    if ({m_cs_addr_val_o, m_pkt_size_val_o} !== 2'b11) begin
      failures++;
      $display("FAIL split_c1 cs=%b sz=%b exp 1 1", m_cs_addr_val_o, m_pkt_size_val_o);
    end
    for (int c = 2; c <= 4; c++) begin
      @(negedge clk);
      m_cs_addr_rdy_i = 1'b0;
      m_pkt_size_rdy_i = (c == 4);
      #1;
      checks++;
      if ({m_cs_addr_val_o, m_pkt_size_val_o, m_recv_val_o} !== 3'b010) begin
        failures++;
        $display("FAIL split_c%0d cs=%b sz=%b recv=%b exp 0 1 0", c, m_cs_addr_val_o, m_pkt_size_val_o, m_recv_val_o);
      end
    end
    @(negedge clk);  // cycle 5: XFER
    m_pkt_size_rdy_i = 1'b0;
    #1;
    checks++;
    if ({m_cs_addr_val_o, m_pkt_size_val_o, m_recv_val_o} !== 3'b001) begin
      failures++;
      $display("FAIL split_c5 cs=%b sz=%b recv=%b exp 0 0 1", m_cs_addr_val_o, m_pkt_size_val_o, m_recv_val_o);
    end
    finish_txn(32'h0BAD_F00D, recv_s, rv_s, rm_s, ok);
    checks++;
    if (ok !== 1'b1 || rv_s !== 4'b0001 || rm_s !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL split_resp ok=%b rv=%b rm=%h exp 1 0001 0badf00d", ok, rv_s, rm_s);
    end
  endtask

  task automatic test_resp_stall();
    logic [NREQ-1:0] rdy_s, rv_s;
    logic [NBITS-1:0] recv_s, rm_s;
    bit ok;
    int n;
    @(negedge clk);
    req_val_i = 4'b0010;
    @(negedge clk);
    req_val_i = 4'b0001;  // competing request arrives while busy
    m_cs_addr_rdy_i = 1'b1;
    m_pkt_size_rdy_i = 1'b1;
    m_recv_rdy_i = 1'b1;
    m_send_val_i = 1'b1;
    m_send_msg_i = 32'h1234_5678;
    n = 0;
    #1;
    while (resp_val_o == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    clear_master();
    checks++;
    if (resp_val_o !== 4'b0010) begin failures++; $display("FAIL stall_reach_resp val=%b exp 0010", resp_val_o); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      resp_rdy_i = (c == 9) ? 4'b1101 : 4'b0000;  // non-granted readies are ignored
      #1;
      checks++;
      if (resp_val_o !== 4'b0010 || resp_msg_o !== 32'h1234_5678 || req_rdy_o !== 4'b0000) begin
        failures++;
        $display("FAIL stall_c%0d val=%b msg=%h req_rdy=%b exp 0010 12345678 0000", c, resp_val_o, resp_msg_o, req_rdy_o);
      end
    end
    @(negedge clk);
    resp_rdy_i = 4'b0010;
    @(negedge clk);
    resp_rdy_i = '0;
    #1;
    checks++;
    if (resp_val_o !== 4'b0000 || busy_o !== 1'b0 || req_rdy_o !== 4'b0001) begin
      failures++;
      $display("FAIL stall_release val=%b busy=%b req_rdy=%b exp 0000 0 0001", resp_val_o, busy_o, req_rdy_o);
    end
    do_txn(32'h0000_0077, rdy_s, recv_s, rv_s, rm_s, ok);
    req_val_i = '0;
    checks++;
    if (ok !== 1'b1 || rv_s !== 4'b0001 || rm_s !== 32'h0000_0077) begin
      failures++;
      $display("FAIL stall_next ok=%b rv=%b rm=%h exp 1 0001 00000077", ok, rv_s, rm_s);
    end
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int wait_cycles = 0;
    int pulses = 0;
    @(negedge clk);
    req_val_i = 4'b0100;
    @(negedge clk);
    req_val_i = '0;
    m_cs_addr_rdy_i = 1'b1;
    m_pkt_size_rdy_i = 1'b1;
    m_recv_rdy_i = 1'b1;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (m_send_rdy_o) wait_cycles++;
      if (timeout_o) pulses++;
      if (resp_val_o != '0) break;
      @(negedge clk);
    end
    clear_master();
    checks++;
    if (wait_cycles !== TIMEOUT || pulses !== 1) begin
      failures++;
      $display("FAIL to_pulse wait_cycles=%0d pulses=%0d exp %0d 1", wait_cycles, pulses, TIMEOUT);
    end
    checks++;
    if (resp_val_o !== 4'b0100 || resp_msg_o !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL to_resp val=%b msg=%h exp 0100 ffffffff", resp_val_o, resp_msg_o);
    end
    m_send_val_i = 1'b1;  // late master answer
    @(negedge clk);
    #1;
    checks++;
    if (m_send_rdy_o !== 1'b0 || resp_msg_o !== 32'hFFFF_FFFF || timeout_o !== 1'b0) begin
      failures++;
      $display("FAIL to_late send_rdy=%b msg=%h to=%b exp 0 ffffffff 0", m_send_rdy_o, resp_msg_o, timeout_o);
    end
    resp_rdy_i = 4'b0100;
    @(negedge clk);
    clear_master();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_reset_mid_xfer();
    test_round_robin();
    test_cfg_split();
    test_resp_stall();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end
endmodule
